// File: rtl/direction_histogram_localizer.sv
// ============================================================================
// Module   : direction_histogram_localizer
// Purpose  : Windowed, magnitude-weighted sector histogram over FRAMES FFT
//            frames, argmax scan, sector + confidence on a valid/ready output.
// Option   : LEAKY_HIST_EN - histogram halves on each decision instead of
//            clearing (temporal smoothing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module direction_histogram_localizer #(
    parameter int NUM_SECTORS     = 16,
    parameter int MAG_WIDTH       = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int LOWER_FFT_BOUND = 9,
    parameter int UPPER_FFT_BOUND = 180,
    parameter int FRAMES          = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [$clog2(NUM_SECTORS)-1:0]   sector_in,
    input  logic [MAG_WIDTH-1:0]             magnitude_in,
    input  logic                             valid_in,
    input  logic                             last_in,
    output logic                             ready_out,
    output logic [$clog2(NUM_SECTORS)-1:0]   sector_out,
    output logic [ACC_WIDTH-1:0]             confidence_out,
    output logic                             angle_valid_out,
    input  logic                             angle_ready_in,
    output logic [$clog2(FRAMES+1)-1:0]      frame_count_out
);

    localparam int SECTOR_W = $clog2(NUM_SECTORS);
    localparam int FC_W     = $clog2(FRAMES + 1);
    localparam int BIN_W    = $clog2(UPPER_FFT_BOUND + 1);

    localparam logic [BIN_W-1:0]    LOWER_B  = BIN_W'(LOWER_FFT_BOUND);
    localparam logic [BIN_W-1:0]    UPPER_B  = BIN_W'(UPPER_FFT_BOUND);
    localparam logic [FC_W-1:0]     FRAMES_C = FC_W'(FRAMES);
    localparam logic [SECTOR_W-1:0] LAST_SEC = SECTOR_W'(NUM_SECTORS - 1);

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    logic [1:0]           state;
    logic [BIN_W-1:0]     bin_idx;
    logic [FC_W-1:0]      frame_count;
    logic [SECTOR_W-1:0]  scan_idx;
    logic [SECTOR_W-1:0]  best_sector;
    logic [ACC_WIDTH-1:0] best_val;
    logic [ACC_WIDTH-1:0] acc [NUM_SECTORS];

    logic                 in_window;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic [FC_W-1:0]      frame_next;
    logic [ACC_WIDTH-1:0] scan_val;
    logic                 scan_better;

    assign ready_out       = (state == ACCUM);
    assign angle_valid_out = (state == EMIT);
    assign frame_count_out = frame_count;

    assign in_window   = (bin_idx > LOWER_B) && (bin_idx < UPPER_B);
    // One extra bit catches the carry so the add can clamp instead of wrap.
    assign sum         = {1'b0, acc[sector_in]} + (ACC_WIDTH+1)'(magnitude_in);
    assign sat_sum     = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    assign frame_next  = frame_count + FC_W'(1);
    assign scan_val    = acc[scan_idx];
    assign scan_better = (scan_val > best_val);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ACCUM;
            bin_idx        <= '0;
            frame_count    <= '0;
            scan_idx       <= '0;
            best_sector    <= '0;
            best_val       <= '0;
            sector_out     <= '0;
            confidence_out <= '0;
            for (int i = 0; i < NUM_SECTORS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (valid_in) begin
                        if (in_window) begin
                            acc[sector_in] <= sat_sum;
                        end
                        if (last_in) begin
                            bin_idx     <= '0;
                            frame_count <= frame_next;
                            if (frame_next == FRAMES_C) begin
                                state       <= SCAN;
                                scan_idx    <= '0;
                                best_sector <= '0;
                                best_val    <= '0;
                            end
                        end else if (bin_idx != UPPER_B) begin
                            bin_idx <= bin_idx + BIN_W'(1);
                        end
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (scan_better) begin
                        best_sector <= scan_idx;
                        best_val    <= scan_val;
                    end
                    if (scan_idx == LAST_SEC) begin
                        sector_out     <= scan_better ? scan_idx : best_sector;
                        confidence_out <= scan_better ? scan_val : best_val;
                        state          <= EMIT;
                    end else begin
                        scan_idx <= scan_idx + SECTOR_W'(1);
                    end
                end
                EMIT: begin
                    if (angle_ready_in) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < NUM_SECTORS; i++) begin
`ifdef LEAKY_HIST_EN
                        acc[i] <= acc[i] >> 1;
`else
                        acc[i] <= '0;
`endif
                    end
                    frame_count <= '0;
                    bin_idx     <= '0;
                    state       <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_direction_histogram_localizer.sv
// Directed self-checking bench for direction_histogram_localizer
// (NUM_SECTORS=4, LOWER=1, UPPER=6, FRAMES=2; second instance with ACC_WIDTH=9).
`default_nettype none

module tb_direction_histogram_localizer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sector;
    logic [7:0]  mag;
    logic        valid;
    logic        last;
    logic        angle_ready;

    logic        ready;
    logic [1:0]  sector_o;
    logic [15:0] conf;
    logic        avalid;
    logic [1:0]  fc;

    logic        sat_ready;
    logic [1:0]  sat_sector;
    logic [8:0]  sat_conf;
    logic        sat_valid;
    logic [1:0]  sat_fc;

    int tests = 0;
    int fails = 0;

    direction_histogram_localizer #(
        .NUM_SECTORS(4), .MAG_WIDTH(8), .ACC_WIDTH(16),
        .LOWER_FFT_BOUND(1), .UPPER_FFT_BOUND(6), .FRAMES(2)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .sector_in(sector), .magnitude_in(mag),
        .valid_in(valid), .last_in(last), .ready_out(ready), .sector_out(sector_o),
        .confidence_out(conf), .angle_valid_out(avalid), .angle_ready_in(angle_ready),
        .frame_count_out(fc)
    );

    direction_histogram_localizer #(
        .NUM_SECTORS(4), .MAG_WIDTH(8), .ACC_WIDTH(9),
        .LOWER_FFT_BOUND(1), .UPPER_FFT_BOUND(6), .FRAMES(2)
    ) dut_sat (
        .clk_in(clk), .rst_n_in(rst_n), .sector_in(sector), .magnitude_in(mag),
        .valid_in(valid), .last_in(last), .ready_out(sat_ready), .sector_out(sat_sector),
        .confidence_out(sat_conf), .angle_valid_out(sat_valid), .angle_ready_in(angle_ready),
        .frame_count_out(sat_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        angle_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [1:0] s, input logic [7:0] m, input logic l);
        valid  = 1'b1;
        sector = s;
        mag    = m;
        last   = l;
        @(posedge clk); #1;
        valid  = 1'b0;
        last   = 1'b0;
    endtask

    // Eight beats, bin indices 0..7, last on the eighth.
    task automatic send_frame(input logic [1:0] s, input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            send_beat(s, m, (i == 7));
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!avalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        angle_ready = 1'b1;
        @(posedge clk); #1;
        angle_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        sector = 2'd0;
        mag = 8'd0;
        angle_ready = 1'b0;
        #12;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0d expected 1", ready); end
        tests++; if (avalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0d expected 0", avalid); end
        tests++; if (sector_o !== 2'd0) begin fails++; $display("FAIL reset_sector: got %0d expected 0", sector_o); end
        tests++; if (conf !== 16'd0) begin fails++; $display("FAIL reset_conf: got %0d expected 0", conf); end
        tests++; if (fc !== 2'd0) begin fails++; $display("FAIL reset_fc: got %0d expected 0", fc); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_window();
        int n;
        apply_reset();
        send_frame(2'd2, 8'd10);
        tests++; if (fc !== 2'd1) begin fails++; $display("FAIL win_fc1: got %0d expected 1", fc); end
        send_frame(2'd2, 8'd10);
        tests++; if (avalid !== 1'b0) begin fails++; $display("FAIL win_valid_early: got %0d expected 0", avalid); end
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL win_latency: got %0d extra edges expected 4", n); end
        tests++; if (sector_o !== 2'd2) begin fails++; $display("FAIL win_sector: got %0d expected 2", sector_o); end
        tests++; if (conf !== 16'd80) begin fails++; $display("FAIL win_conf: got %0d expected 80", conf); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL win_ready_emit: got %0d expected 0", ready); end
        handshake();
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL win_ready_back: got %0d expected 1", ready); end
        tests++; if (fc !== 2'd0) begin fails++; $display("FAIL win_fc_clear: got %0d expected 0", fc); end
    endtask

    task automatic test_argmax();
        int n;
        apply_reset();
        send_beat(2'd0, 8'd0, 1'b0);
        send_beat(2'd0, 8'd0, 1'b0);
        send_beat(2'd1, 8'd30, 1'b0);
        send_beat(2'd3, 8'd30, 1'b0);
        send_beat(2'd0, 8'd0, 1'b0);
        send_beat(2'd0, 8'd0, 1'b1);
        send_beat(2'd2, 8'd99, 1'b1);   // bin 0 frame: counted, not accumulated
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL tie_latency: got %0d expected 4", n); end
        tests++; if (sector_o !== 2'd1) begin fails++; $display("FAIL tie_sector: got %0d expected 1", sector_o); end
        tests++; if (conf !== 16'd30) begin fails++; $display("FAIL tie_conf: got %0d expected 30", conf); end
        handshake();

        apply_reset();
        angle_ready = 1'b1;
        send_beat(2'd1, 8'd50, 1'b1);
        send_beat(2'd3, 8'd77, 1'b1);
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL zero_latency: got %0d expected 4", n); end
        tests++; if (sector_o !== 2'd0) begin fails++; $display("FAIL zero_sector: got %0d expected 0", sector_o); end
        tests++; if (conf !== 16'd0) begin fails++; $display("FAIL zero_conf: got %0d expected 0", conf); end
        @(posedge clk); #1;
        tests++; if (avalid !== 1'b0) begin fails++; $display("FAIL zero_hs_valid: got %0d expected 0", avalid); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL zero_clear_ready: got %0d expected 0", ready); end
        angle_ready = 1'b0;
        @(posedge clk); #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL zero_ready_back: got %0d expected 1", ready); end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        send_frame(2'd3, 8'd5);
        send_frame(2'd3, 8'd5);
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL bp_latency: got %0d expected 4", n); end
        for (int c = 0; c < 10; c++) begin
            valid  = 1'b1;
            sector = 2'd3;
            mag    = 8'd100;
            last   = 1'b1;
            @(posedge clk); #1;
            tests++;
            if ({avalid, ready, sector_o, conf} !== {1'b1, 1'b0, 2'd3, 16'd40}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: got valid=%0d ready=%0d sector=%0d conf=%0d expected valid=1 ready=0 sector=3 conf=40",
                         c, avalid, ready, sector_o, conf);
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        tests++; if (fc !== 2'd2) begin fails++; $display("FAIL bp_fc: got %0d expected 2", fc); end
        angle_ready = 1'b1;
        @(posedge clk); #1;
        angle_ready = 1'b0;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL bp_ready_clear: got %0d expected 0", ready); end
        @(posedge clk); #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %0d expected 1", ready); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        send_frame(2'd3, 8'd5);
        send_frame(2'd3, 8'd5);
        wait_valid(n);
        handshake();
        tests++; if (sector_o !== 2'd3) begin fails++; $display("FAIL ar_held_sector: got %0d expected 3", sector_o); end
        tests++; if (conf !== 16'd40) begin fails++; $display("FAIL ar_held_conf: got %0d expected 40", conf); end
        send_frame(2'd1, 8'd20);
        send_frame(2'd1, 8'd20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ar_ready: got %0d expected 1", ready); end
        tests++; if (avalid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %0d expected 0", avalid); end
        tests++; if (sector_o !== 2'd0) begin fails++; $display("FAIL ar_sector: got %0d expected 0", sector_o); end
        tests++; if (conf !== 16'd0) begin fails++; $display("FAIL ar_conf: got %0d expected 0", conf); end
        tests++; if (fc !== 2'd0) begin fails++; $display("FAIL ar_fc: got %0d expected 0", fc); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(2'd2, 8'd1);
        send_frame(2'd2, 8'd1);
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL ar_latency: got %0d expected 4", n); end
        tests++; if (sector_o !== 2'd2) begin fails++; $display("FAIL ar_post_sector: got %0d expected 2", sector_o); end
        tests++; if (conf !== 16'd8) begin fails++; $display("FAIL ar_post_conf: got %0d expected 8", conf); end
        handshake();
    endtask

    task automatic test_saturation();
        int n;
        apply_reset();
        send_frame(2'd0, 8'd255);
        send_frame(2'd0, 8'd255);
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL sat_latency: got %0d expected 4", n); end
        tests++; if (conf !== 16'd2040) begin fails++; $display("FAIL sat_wide_conf: got %0d expected 2040", conf); end
        tests++; if (sat_valid !== 1'b1) begin fails++; $display("FAIL sat_valid: got %0d expected 1", sat_valid); end
        tests++; if (sat_sector !== 2'd0) begin fails++; $display("FAIL sat_sector: got %0d expected 0", sat_sector); end
        tests++; if (sat_conf !== 9'd511) begin fails++; $display("FAIL sat_conf: got %0d expected 511", sat_conf); end
        handshake();
    endtask

    task automatic test_leaky();
        int n;
        logic [1:0]  exp_sector;
        logic [15:0] exp_conf;
`ifdef LEAKY_HIST_EN
        exp_sector = 2'd2;
        exp_conf   = 16'd40;
`else
        exp_sector = 2'd0;
        exp_conf   = 16'd0;
`endif
        apply_reset();
        send_frame(2'd2, 8'd10);
        send_frame(2'd2, 8'd10);
        wait_valid(n);
        tests++; if (conf !== 16'd80) begin fails++; $display("FAIL leak_first_conf: got %0d expected 80", conf); end
        handshake();
        send_frame(2'd0, 8'd0);
        send_frame(2'd0, 8'd0);
        wait_valid(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL leak_latency: got %0d expected 4", n); end
        tests++; if (sector_o !== exp_sector) begin fails++; $display("FAIL leak_sector: got %0d expected %0d", sector_o, exp_sector); end
        tests++; if (conf !== exp_conf) begin fails++; $display("FAIL leak_conf: got %0d expected %0d", conf, exp_conf); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_window();
        test_argmax();
        test_backpressure();
        test_async_reset();
        test_saturation();
        test_leaky();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
